// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the gray counter family.
// Functions work on GRAY_MAX_W bits; callers cast to and from their own width.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    localparam logic [GRAY_MAX_W-1:0] GRAY_ONES = '1;
    localparam logic [GRAY_MAX_W-1:0] GRAY_ZERO = '0;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Sticky monitor: flags any qualified count step whose Gray output
// does not change in exactly one bit.
module gray_step_chk
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             step_vld,
    input  logic [WIDTH-1:0] gray_prev,
    input  logic [WIDTH-1:0] gray_next,
    output logic             StepErr
);

    logic bad_step;

    assign bad_step = step_vld && ($countones(gray_prev ^ gray_next) != 1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            StepErr <= 1'b0;
        end else if (Clear) begin
            StepErr <= 1'b0;
        end else if (bad_step) begin
            StepErr <= 1'b1;
        end
    end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with load, clear, wrap/saturate and sticky flags.
// Optional step checker (StepErr port) is built when GRAY_COUNTER_STEPCHK_EN is defined.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int          WIDTH = 3,
    parameter bit          WRAP  = 1'b1,
    parameter int unsigned INIT  = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             En,
    input  logic             Up,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Underflow
`ifdef GRAY_COUNTER_STEPCHK_EN
    ,
    output logic             StepErr
`endif
);

    localparam logic [WIDTH-1:0] ONES   = GRAY_ONES[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO   = GRAY_ZERO[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return WIDTH'(bin2gray(GRAY_MAX_W'(b)));
    endfunction

    logic [WIDTH-1:0] bin_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    always_comb begin
        bin_nxt = BinOut;
        ovf_nxt = Overflow;
        unf_nxt = Underflow;
        if (Clear) begin
            bin_nxt = INIT_V;
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
        end else if (Load) begin
            bin_nxt = LoadVal;
        end else if (En) begin
            if (Up) begin
                if (BinOut == ONES) begin
                    ovf_nxt = 1'b1;
                    if (WRAP) bin_nxt = ZERO;
                end else begin
                    bin_nxt = BinOut + WIDTH'(1);
                end
            end else begin
                if (BinOut == ZERO) begin
                    unf_nxt = 1'b1;
                    if (WRAP) bin_nxt = ONES;
                end else begin
                    bin_nxt = BinOut - WIDTH'(1);
                end
            end
        end
    end

    // Binary and Gray views update on the same edge so they always agree
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            BinOut    <= INIT_V;
            Output    <= to_gray(INIT_V);
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            BinOut    <= bin_nxt;
            Output    <= to_gray(bin_nxt);
            Overflow  <= ovf_nxt;
            Underflow <= unf_nxt;
        end
    end

`ifdef GRAY_COUNTER_STEPCHK_EN
    logic sat_hold;
    logic step_vld;

    assign sat_hold = !WRAP && ((Up && BinOut == ONES) || (!Up && BinOut == ZERO));
    assign step_vld = En && !Clear && !Load && !sat_hold;

    gray_step_chk #(.WIDTH(WIDTH)) u_step_chk (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Clear     (Clear),
        .step_vld  (step_vld),
        .gray_prev (Output),
        .gray_next (to_gray(bin_nxt)),
        .StepErr   (StepErr)
    );
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: 3-bit wrap, 4-bit saturate, 5-bit random walk.
module tb_gray_counter_param;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset_n, Clear, Load, En, Up;
    logic [2:0] ld3;
    logic [3:0] ld4;
    logic [4:0] ld5;

    logic [2:0] g3, b3;
    logic [3:0] g4, b4;
    logic [4:0] g5, b5;
    logic o3, uf3, o4, uf4, o5, uf5;
`ifdef GRAY_COUNTER_STEPCHK_EN
    logic se3, se4, se5;
`endif

    gray_counter_param #(.WIDTH(3), .WRAP(1'b1), .INIT(0)) u3 (
        .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Load(Load), .LoadVal(ld3),
        .En(En), .Up(Up), .Output(g3), .BinOut(b3), .Overflow(o3), .Underflow(uf3)
`ifdef GRAY_COUNTER_STEPCHK_EN
        , .StepErr(se3)
`endif
    );

    gray_counter_param #(.WIDTH(4), .WRAP(1'b0), .INIT(0)) u4 (
        .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Load(Load), .LoadVal(ld4),
        .En(En), .Up(Up), .Output(g4), .BinOut(b4), .Overflow(o4), .Underflow(uf4)
`ifdef GRAY_COUNTER_STEPCHK_EN
        , .StepErr(se4)
`endif
    );

    gray_counter_param #(.WIDTH(5), .WRAP(1'b1), .INIT(0)) u5 (
        .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Load(Load), .LoadVal(ld5),
        .En(En), .Up(Up), .Output(g5), .BinOut(b5), .Overflow(o5), .Underflow(uf5)
`ifdef GRAY_COUNTER_STEPCHK_EN
        , .StepErr(se5)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        Clear   = 1'b0;
        Load    = 1'b0;
        En      = 1'b0;
        Up      = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    function automatic logic [4:0] g2b5(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    int exp3 [8] = '{1, 3, 2, 6, 7, 5, 4, 0};

    initial begin
        logic [4:0] m;
        logic       m_ovf, m_unf, en_r, up_r;

        Reset_n = 1'b0;
        Clear   = 1'b0;
        Load    = 1'b0;
        En      = 1'b0;
        Up      = 1'b1;
        ld3     = 3'd0;
        ld4     = 4'd0;
        ld5     = 5'd0;
        #3;
        check("rst bin3", 32'(b3), 0);
        check("rst gray3", 32'(g3), 0);
        check("rst ovf3", 32'(o3), 0);
        check("rst unf3", 32'(uf3), 0);
        do_reset();

        // 3-bit up count through wrap
        En = 1'b1;
        Up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("up3 gray[%0d]", i), 32'(g3), 32'(exp3[i]));
            check($sformatf("up3 ovf[%0d]", i), 32'(o3), (i == 7) ? 1 : 0);
        end
        En = 1'b0;
        tick();
        tick();
        check("ovf3 sticky", 32'(o3), 1);
        check("hold bin3", 32'(b3), 0);

        // Down step from zero: wrap vs saturate
        do_reset();
        Up = 1'b0;
        En = 1'b1;
        tick();
        En = 1'b0;
        check("dn3 bin", 32'(b3), 7);
        check("dn3 gray", 32'(g3), 4);
        check("dn3 unf", 32'(uf3), 1);
        check("dn3 ovf", 32'(o3), 0);
        check("dn4 sat bin", 32'(b4), 0);
        check("dn4 unf", 32'(uf4), 1);

        // Load then saturate up on 4-bit WRAP=0
        Load = 1'b1;
        ld4  = 4'b1110;
        tick();
        Load = 1'b0;
        check("ld4 bin", 32'(b4), 14);
        check("ld4 gray", 32'(g4), 9);
        check("ld4 unf kept", 32'(uf4), 1);
        En = 1'b1;
        Up = 1'b1;
        tick();
        check("sat1 bin", 32'(b4), 15);
        check("sat1 gray", 32'(g4), 8);
        check("sat1 ovf", 32'(o4), 0);
        tick();
        check("sat2 bin", 32'(b4), 15);
        check("sat2 ovf", 32'(o4), 1);
        tick();
        check("sat3 bin", 32'(b4), 15);
        check("sat3 gray", 32'(g4), 8);

        // Clear beats Load beats En
        Clear = 1'b1;
        Load  = 1'b1;
        ld4   = 4'b0101;
        tick();
        check("clr bin4", 32'(b4), 0);
        check("clr ovf4", 32'(o4), 0);
        check("clr unf4", 32'(uf4), 0);
        Clear = 1'b0;
        En    = 1'b0;
        tick();
        Load = 1'b0;
        check("ld bin4", 32'(b4), 5);
        check("ld gray4", 32'(g4), 7);

        // Asynchronous reset between edges
        En = 1'b1;
        tick();
        En = 1'b0;
        check("pre-rst bin4", 32'(b4), 6);
        check("pre-rst gray4", 32'(g4), 5);
        Reset_n = 1'b0;
        #2;
        check("async bin4", 32'(b4), 0);
        check("async gray4", 32'(g4), 0);
        #1;
        Reset_n = 1'b1;
        En = 1'b1;
        Up = 1'b1;
        tick();
        En = 1'b0;
        check("post-rst bin4", 32'(b4), 1);

        // Random walk on 5-bit wrap counter
        do_reset();
        m     = 5'd0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            en_r = 1'($urandom_range(0, 1));
            up_r = 1'($urandom_range(0, 1));
            En = en_r;
            Up = up_r;
            tick();
            if (en_r) begin
                if (up_r) begin
                    if (m == 5'd31) m_ovf = 1'b1;
                    m = m + 5'd1;
                end else begin
                    if (m == 5'd0) m_unf = 1'b1;
                    m = m - 5'd1;
                end
            end
            check("rnd bin5", 32'(b5), 32'(m));
            check("rnd gray5", 32'(g5), 32'(m ^ (m >> 1)));
            check("rnd g2b5", 32'(g2b5(g5)), 32'(b5));
        end
        En = 1'b0;
        check("rnd ovf5", 32'(o5), 32'(m_ovf));
        check("rnd unf5", 32'(uf5), 32'(m_unf));
`ifdef GRAY_COUNTER_STEPCHK_EN
        check("steperr5", 32'(se5), 0);
        check("steperr4", 32'(se4), 0);
        check("steperr3", 32'(se3), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
